// File: rtl/switch_egress_queue.sv
// Egress buffer for one destination port of the switch.
// Words addressed to PORT_ID are queued in a first-word-fall-through FIFO.
// The FIFO drains over a valid/ready handshake. Accepted words and words
// dropped because the queue was full are counted.
module switch_egress_queue #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int PORT_ID = 0,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [ADDR_W-1:0]          dst_addr,
    input  logic [DATA_W-1:0]          dst_data,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           accept_cnt,
    input  logic                       clr_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level_nxt;
    logic              match;
    logic              push;
    logic              pop;
    logic              drop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign match = in_valid && (dst_addr == ADDR_W'(PORT_ID));
    assign pop   = out_valid && out_ready;
    assign push  = match && (!full || pop);
    assign drop  = match && full && !pop;

    // The head word is only meaningful while valid; drive zero when empty.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    // Next occupancy: push and pop together leave the level unchanged.
    always_comb begin
        // NOTE: default assignment first so no path leaves level_nxt unassigned (no latch).
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Storage write; the array holds no control state.
    // NOTE: memory is intentionally not reset; the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dst_data;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level     <= level_nxt;
            full      <= (level_nxt == LVL_W'(DEPTH));
            empty     <= (level_nxt == '0);
            out_valid <= (level_nxt != '0);
        end
    end

    // Saturating statistics counters; a clear wins over an increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt   <= '0;
            accept_cnt <= '0;
        end else if (clr_cnt) begin
            drop_cnt   <= '0;
            accept_cnt <= '0;
        end else begin
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (push && (accept_cnt != '1)) begin
                accept_cnt <= accept_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_egress_queue.sv
// Self-checking bench for switch_egress_queue (PORT_ID = 3, DEPTH = 8).
// A negedge monitor keeps a reference queue of expected words and compares
// the head word every cycle; scenario tasks check levels and counters.
module tb_switch_egress_queue;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int PORT   = 3;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [3:0]        level;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  accept_cnt;
    logic              clr_cnt;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    switch_egress_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PORT_ID(PORT),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt),
        .accept_cnt(accept_cnt),
        .clr_cnt   (clr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: compare head word and level, then predict the coming edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            bit mdl_full;
            bit mdl_pop;
            bit mdl_match;
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL sb_valid got %0b want %0b", out_valid, exp_q.size() != 0);
            end
            checks++;
            if (exp_q.size() != 0) begin
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sb_data got %h want %h", out_data, exp_q[0]);
                end
            end else if (out_data !== '0) begin
                errors++;
                $display("FAIL sb_data_empty got %h want 0", out_data);
            end
            checks++;
            if (level !== 4'(exp_q.size())) begin
                errors++;
                $display("FAIL sb_level got %0d want %0d", level, exp_q.size());
            end
            mdl_full  = (exp_q.size() == DEPTH);
            mdl_pop   = (exp_q.size() != 0) && (out_ready === 1'b1);
            mdl_match = (in_valid === 1'b1) && (dst_addr === ADDR_W'(PORT));
            if (mdl_pop) void'(exp_q.pop_front());
            if (mdl_match && (!mdl_full || mdl_pop)) exp_q.push_back(dst_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        in_valid = v;
        dst_addr = a;
        dst_data = d;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0);
    endtask

    task automatic clear_counters();
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (empty) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (empty) ok = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %0b want 0", full); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_data got %h want 0", out_data); end
        checks++; if (drop_cnt !== 16'd0 || accept_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", drop_cnt, accept_cnt);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 8'd3, 32'hA5A5_0001);
        cyc();
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got %h want a5a50001", out_data); end
        checks++; if (accept_cnt !== 16'd1) begin errors++; $display("FAIL single_accept got %0d want 1", accept_cnt); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got %0b want 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_level got %0d want 0", level); end
    endtask

    task automatic test_ignore();
        clear_counters();
        for (int i = 0; i < 4; i++) begin drive(1'b1, 8'd5, 32'h5500 + i); cyc(); end
        for (int i = 0; i < 4; i++) begin drive(1'b0, 8'd3, 32'h3300 + i); cyc(); end
        idle();
        checks++; if (level !== 4'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL ignore_level got %0d/%0b want 0/1", level, empty);
        end
        checks++; if (drop_cnt !== 16'd0 || accept_cnt !== 16'd0) begin
            errors++; $display("FAIL ignore_cnt got %0d/%0d want 0/0", drop_cnt, accept_cnt);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_counters();
        out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 8'd3, 32'(i));
            cyc();
            if (i == 8) begin
                checks++; if (full !== 1'b1 || level !== 4'd8) begin
                    errors++; $display("FAIL ovf_full got %0b/%0d want 1/8", full, level);
                end
            end
        end
        idle();
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
        checks++; if (accept_cnt !== 16'd8) begin errors++; $display("FAIL ovf_accept got %0d want 8", accept_cnt); end
        out_ready = 1'b1;
        wait_empty(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got level %0d want empty", level); end
    endtask

    task automatic test_full_stream();
        bit ok;
        clear_counters();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin drive(1'b1, 8'd3, 32'h20 + i); cyc(); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL stream_full got %0b want 1", full); end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'd3, 32'h99);
            cyc();
            checks++; if (level !== 4'd8) begin errors++; $display("FAIL stream_level cyc %0d got %0d want 8", i, level); end
        end
        idle();
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL stream_drop got %0d want 0", drop_cnt); end
        checks++; if (accept_cnt !== 16'd28) begin errors++; $display("FAIL stream_accept got %0d want 28", accept_cnt); end
        wait_empty(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stream_drain got level %0d want empty", level); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic              stall;
        logic [DATA_W-1:0] held;
        clear_counters();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'd3, 32'h10 + i);
            out_ready = (i % 2 == 1);
            stall = out_valid && !out_ready;
            held  = out_data;
            cyc();
            if (stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++; $display("FAIL bp_stable cyc %0d got %b/%h want 1/%h", i, out_valid, out_data, held);
                end
            end
        end
        idle();
        out_ready = 1'b1;
        wait_empty(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain got level %0d want empty", level); end
        checks++; if (accept_cnt !== 16'd16 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL bp_cnt got %0d/%0d want 16/0", accept_cnt, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_counters();
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin drive(1'b1, 8'd3, 32'h30 + i); cyc(); end
        idle();
        out_ready = 1'b1;
        repeat (3) cyc();
        out_ready = 1'b0;
        checks++; if (level !== 4'd5 || drop_cnt !== 16'd3) begin
            errors++; $display("FAIL mid_pre got %0d/%0d want 5/3", level, drop_cnt);
        end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL mid_flags got %b%b%b want 010", out_valid, empty, full);
        end
        checks++; if (level !== 4'd0 || out_data !== 32'd0) begin
            errors++; $display("FAIL mid_level got %0d/%h want 0/0", level, out_data);
        end
        checks++; if (drop_cnt !== 16'd0 || accept_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_cnt got %0d/%0d want 0/0", drop_cnt, accept_cnt);
        end
        repeat (2) cyc();
        reset_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'd3, 32'h77);
        cyc();
        idle();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin
            errors++; $display("FAIL mid_first got %b/%h want 1/00000077", out_valid, out_data);
        end
        cyc();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %0b want 1", empty); end
    endtask

    task automatic test_clr_drop();
        bit ok;
        clear_counters();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin drive(1'b1, 8'd3, 32'h40 + i); cyc(); end
        drive(1'b1, 8'd3, 32'h48);
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        checks++; if (drop_cnt !== 16'd0 || accept_cnt !== 16'd0) begin
            errors++; $display("FAIL clr_prio got %0d/%0d want 0/0", drop_cnt, accept_cnt);
        end
        drive(1'b1, 8'd3, 32'h49);
        cyc();
        idle();
        checks++; if (drop_cnt !== 16'd1 || level !== 4'd8) begin
            errors++; $display("FAIL clr_resume got %0d/%0d want 1/8", drop_cnt, level);
        end
        out_ready = 1'b1;
        wait_empty(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clr_drain got level %0d want empty", level); end
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        idle();
        repeat (2) cyc();
        test_reset();
        reset_n = 1'b1;
        cyc();
        test_single();
        test_ignore();
        test_overflow();
        test_full_stream();
        test_back_to_back();
        test_reset_mid();
        test_clr_drop();
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
